uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one `uart` transmitter between N_REQ requesters.
- Each requester offers a vector of N_NUMS `num` values (16-bit signed).
- The block latches the winner's vector onto `tx_nums`, pulses `send_data`, and tracks `tx_ready` through busy and idle.
- It reports completion or timeout to the winner. It sits between the datapath blocks and the `uart` instance's tx side.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- N_NUMS, 5, numbers per vector; must equal the `uart` n_tx_nums.
- TIMEOUT, 200000, max cycles from `send_data` pulse to `tx_ready` returning high.
- BUSY_WIN, 4, max cycles after `send_data` for `tx_ready` to fall.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester send request; held high until its done/err pulse.
- req_new  in  N_REQ  per-requester "first vector of a new frame" flag, sampled with req.
- req_nums  in  N_REQ x N_NUMS x 16  unpacked array `num req_nums[N_REQ-1:0][N_NUMS-1:0]`.
- grant  out  N_REQ  one-hot; current owner of the transmitter.
- done  out  N_REQ  one-cycle pulse to the owner on successful send.
- err  out  N_REQ  one-cycle pulse to the owner on timeout.
- tx_nums  out  N_NUMS x 16  to `uart` tx_nums; registered.
- send_data  out  1  to `uart`; one-cycle pulse.
- new_vector_incoming  out  1  to `uart`; high only in the `send_data` cycle.
- tx_ready  in  1  from `uart`; high when the transmitter is idle.
- busy  out  1  high from acceptance until return to IDLE.

Behaviour:
- Reset (async, immediate) clears:
  - grant, done, err, send_data, new_vector_incoming, busy = 0
  - tx_nums = all 0
  - rr pointer = 0
  - state = IDLE
- Reset mid-transfer abandons the transfer without a done/err pulse. Requesters re-request after reset.
- States: IDLE, SEND, WAIT_BUSY, WAIT_IDLE, FINISH.
- IDLE:
  - If tx_ready=1 and any req bit is set, select winner w = first set bit at or after the rr pointer, wrapping modulo N_REQ.
  - At the next edge, register:
    - tx_nums <= req_nums[w]
    - grant <= onehot(w)
    - send_data <= 1
    - new_vector_incoming <= req_new[w]
    - busy <= 1
    - cycle counter <= 0
    - state <= SEND
  - If tx_ready=0, stay in IDLE and grant nothing.
- SEND: exactly one cycle with send_data=1. At the next edge, send_data and new_vector_incoming return to 0 and state becomes WAIT_BUSY.
- WAIT_BUSY:
  - tx_ready=0 → WAIT_IDLE.
  - If BUSY_WIN cycles elapse since SEND with tx_ready still high, treat it as an instant send and go to FINISH with success. This covers a uart that completes within one cycle.
- WAIT_IDLE:
  - tx_ready=1 → FINISH with success.
  - Counter reaching TIMEOUT → FINISH with failure.
- FINISH:
  - For one cycle, pulse done[w] on success or err[w] on failure.
  - At the next edge: grant <= 0, busy <= 0, rr pointer <= (w+1) mod N_REQ, state <= IDLE.
- tx_nums holds the last sent vector until the next acceptance; it never changes while busy=1.
- req_nums changes while granted have no effect.
- Dropping req while granted does not abort the transfer; done/err still pulse.
- Minimum gap between grants is 1 IDLE cycle, so back-to-back requests are accepted at most every 4 + uart-busy cycles.
- Counter is ceil(log2(TIMEOUT+1)) bits wide and saturates; no wrap-around.

Test Plan:
- Single request:
  - Stimulus: reset 100ns; req=01, req_new=01, req_nums[0]={F6A5,FEDA,FD3C,00C1,DABE}; uart model holds tx_ready low 20 cycles.
  - Response: send_data is high exactly 1 cycle, 1 cycle after req; tx_nums equals that vector; new_vector_incoming=1 in the same cycle; done[0] pulses 2 cycles after tx_ready rises; grant then clears.
- Contention:
  - Stimulus: req=11 from IDLE with pointer 0; req_nums[1][0]=5501.
  - Response: requester 0 is served first, then requester 1 (tx_nums[0]=5501). Order is 0,1,0,1 over 4 continuous requests.
- Transmitter not ready:
  - Stimulus: tx_ready held low for 50 cycles while req=01.
  - Response: no grant and no send_data until the cycle after tx_ready=1.
- Timeout:
  - Stimulus: TIMEOUT=100; uart model never raises tx_ready after the send.
  - Response: err[0] pulses at cycle 101±1 after send_data; done stays 0; busy returns to 0.
- Reset mid-operation:
  - Stimulus: assert reset during WAIT_IDLE.
  - Response: all outputs go 0 immediately (asynchronous); no done/err pulse; a fresh request after reset is served by requester 0 first.
- Loopback:
  - Stimulus: drive a real `uart` instance, with its tx wired to a second `uart`'s rx.
  - Response: the receiver's rx_nums equals the sent vector and rx_available rises.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter that shares one uart transmitter among
// N_REQ requesters. The winner's vector is latched onto tx_nums, send_data is
// pulsed for one cycle, and tx_ready is followed through busy and back to idle.
// Completion (done) or timeout (err) is then pulsed back to the winner.
//
// Handshake: a requester raises req and holds it, together with req_new and
// req_nums, until it sees its own done or err pulse. The request is accepted
// (grant rises) only when the scheduler is idle and the uart reports tx_ready=1.
// The vector is captured at acceptance, so later changes to req_nums or req
// while the requester is granted do not affect the transfer in flight.
module uart_tx_sched #(
    parameter int N_REQ    = 2,
    parameter int N_NUMS   = 5,
    parameter int TIMEOUT  = 200000,
    parameter int BUSY_WIN = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_new,
    input  logic signed [15:0]      req_nums [N_REQ-1:0][N_NUMS-1:0],
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic signed [15:0]      tx_nums [N_NUMS-1:0],
    output logic                    send_data,
    output logic                    new_vector_incoming,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic [2:0]              dbg_state
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_IDLE = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       rr_q, rr_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [N_REQ-1:0]    err_q, err_d;
    logic                send_q, send_d;
    logic                nvi_q, nvi_d;
    logic                busy_q, busy_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic signed [15:0]  tx_nums_q [N_NUMS-1:0];
    logic signed [15:0]  tx_nums_d [N_NUMS-1:0];

    logic                pick_hit;
    logic [PW-1:0]       pick_idx;
    logic [N_REQ-1:0]    pick_oh;

    // Winner search: first set request at or after the rr pointer, wrapping.
    // Scanned from the farthest offset down so the nearest one wins.
    always_comb begin
        logic [PW:0] idx;
        pick_hit = 1'b0;
        pick_idx = '0;
        idx      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(N_REQ)) begin
                idx = idx - (PW+1)'(N_REQ);
            end
            if (req[idx[PW-1:0]]) begin
                pick_hit = 1'b1;
                pick_idx = idx[PW-1:0];
            end
        end
        pick_oh = N_REQ'(1) << pick_idx;
    end

    // Next-state and next-output logic of the transfer sequencer.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        send_d    = 1'b0;
        nvi_d     = 1'b0;
        busy_d    = busy_q;
        tx_nums_d = tx_nums_q;
        // Elapsed-cycle counter; saturates instead of wrapping.
        cnt_d     = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                if (tx_ready && pick_hit) begin
                    owner_d = pick_idx;
                    grant_d = pick_oh;
                    send_d  = 1'b1;
                    nvi_d   = |(req_new & pick_oh);
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SEND;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (PW'(i) == pick_idx) begin
                            tx_nums_d = req_nums[i];
                        end
                    end
                end
            end
            S_SEND: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_d = S_WAIT_IDLE;
                end else if (cnt_q >= CW'(BUSY_WIN)) begin
                    // uart never showed busy: it finished within a cycle.
                    state_d = S_FINISH;
                    done_d  = grant_q;
                end
            end
            S_WAIT_IDLE: begin
                if (tx_ready) begin
                    state_d = S_FINISH;
                    done_d  = grant_q;
                end else if (cnt_q >= CW'(TIMEOUT)) begin
                    state_d = S_FINISH;
                    err_d   = grant_q;
                end
            end
            S_FINISH: begin
                grant_d = '0;
                busy_d  = 1'b0;
                rr_d    = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transfer silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            send_q    <= 1'b0;
            nvi_q     <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            tx_nums_q <= '{default: '0};
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            send_q    <= send_d;
            nvi_q     <= nvi_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            tx_nums_q <= tx_nums_d;
        end
    end

    assign grant               = grant_q;
    assign done                = done_q;
    assign err                 = err_q;
    assign send_data           = send_q;
    assign new_vector_incoming = nvi_q;
    assign busy                = busy_q;
    assign tx_nums             = tx_nums_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a driver plays requesters and a behavioural uart,
// a reference model predicts the round-robin winner and the outcome, and a
// negedge monitor pops those predictions whenever the DUT sends or finishes.
module tb_uart_tx_sched;

    localparam int N_REQ    = 2;
    localparam int N_NUMS   = 5;
    localparam int TIMEOUT  = 100;
    localparam int BUSY_WIN = 4;
    localparam int NW       = 16 * N_NUMS;
    localparam int W        = N_REQ + 1 + NW;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N_REQ-1:0]    req = '0;
    logic [N_REQ-1:0]    req_new = '0;
    logic signed [15:0]  req_nums [N_REQ-1:0][N_NUMS-1:0];
    logic [N_REQ-1:0]    grant, done, err;
    logic signed [15:0]  tx_nums [N_NUMS-1:0];
    logic                send_data, new_vector_incoming, busy;
    logic                tx_ready = 1'b1;
    logic [2:0]          dbg_state;

    uart_tx_sched #(
        .N_REQ(N_REQ), .N_NUMS(N_NUMS), .TIMEOUT(TIMEOUT), .BUSY_WIN(BUSY_WIN)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_new(req_new),
        .req_nums(req_nums), .grant(grant), .done(done), .err(err),
        .tx_nums(tx_nums), .send_data(send_data),
        .new_vector_incoming(new_vector_incoming), .tx_ready(tx_ready),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0]         exp_q[$];   // {grant, new flag, packed nums} per send
    logic [2*N_REQ-1:0]   res_q[$];   // {done, err} per transfer
    int                   n_checks = 0;
    int                   n_fail   = 0;
    int                   model_rr = 0;
    logic [NW-1:0]        last_nums = '0;
    logic                 prev_send = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [NW-1:0] pack_tx();
        logic [NW-1:0] v;
        for (int j = 0; j < N_NUMS; j++) v[16*j +: 16] = tx_nums[j];
        return v;
    endfunction

    function automatic logic [NW-1:0] pack_req(input int w);
        logic [NW-1:0] v;
        for (int j = 0; j < N_NUMS; j++) v[16*j +: 16] = req_nums[w][j];
        return v;
    endfunction

    // Reference model: first requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N_REQ-1:0] r, input int ptr);
        for (int i = 0; i < N_REQ; i++) begin
            if (r[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
        end
        return -1;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0]         e;
        logic [2*N_REQ-1:0]   r;
        if (!reset) begin
            if (send_data) begin
                check("send_single_cycle", prev_send, 1'b0);
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_send: grant %0h with nothing expected", grant);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_at_send", grant, e[W-1 -: N_REQ]);
                    check("new_vector_incoming", new_vector_incoming, e[NW]);
                    check("tx_nums_at_send", pack_tx(), e[NW-1:0]);
                    check("busy_at_send", busy, 1'b1);
                    last_nums = e[NW-1:0];
                end
            end else begin
                check("nvi_outside_send", new_vector_incoming, 1'b0);
                if (busy) check("tx_nums_hold", pack_tx(), last_nums);
            end
            if (done != '0 || err != '0) begin
                if (res_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_outcome: done %0h err %0h", done, err);
                end else begin
                    r = res_q.pop_front();
                    check("outcome_done_err", {done, err}, r);
                end
            end
            prev_send = send_data;
        end else begin
            prev_send = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic randomize_nums();
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < N_NUMS; j++)
                req_nums[i][j] = 16'($urandom);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req = '0;
        tx_ready = 1'b1;
        exp_q.delete();
        res_q.delete();
        model_rr = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {grant, done, err, send_data, new_vector_incoming, busy, pack_tx()}, '0);
        reset = 1'b0;
    endtask

    task automatic wait_send(output int k);
        k = 0;
        while (!send_data && k < 20) begin
            @(negedge clk); #1; k++;
        end
    endtask

    task automatic wait_outcome(input int limit, output int k);
        k = 0;
        while (done == '0 && err == '0 && k < limit) begin
            @(negedge clk); #1; k++;
        end
    endtask

    // One transfer. mode 0: uart busy for busy_len cycles; 1: uart finishes
    // instantly (never drops tx_ready); 2: uart never returns to idle.
    task automatic run_round(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] nw,
                             input int mode, input int pre_low, input int busy_len,
                             input bit drop_early);
        int w, k;
        logic [N_REQ-1:0] oh;
        w = model_pick(r, model_rr);
        oh = '0;
        oh[w] = 1'b1;
        exp_q.push_back({oh, nw[w], pack_req(w)});
        res_q.push_back((mode == 2) ? {{N_REQ{1'b0}}, oh} : {oh, {N_REQ{1'b0}}});
        @(negedge clk); #1;
        req = r;
        req_new = nw;
        tx_ready = (pre_low == 0);
        for (int c = 0; c < pre_low; c++) begin
            @(negedge clk); #1;
            check("no_grant_not_ready", {grant, send_data}, '0);
        end
        tx_ready = 1'b1;
        wait_send(k);
        if (!send_data) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: no send_data within %0d cycles", k);
            return;
        end
        check("send_latency", k, 1);
        // Granted data changes must not disturb the transfer in flight.
        randomize_nums();
        if (drop_early) req = '0;
        if (mode == 0) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1 tx_ready = 1'b0;
            repeat (busy_len) @(negedge clk);
            #1 tx_ready = 1'b1;
            wait_outcome(20, k);
            check_range("done_latency_after_ready", k, 1, 2);
        end else if (mode == 1) begin
            wait_outcome(20, k);
            check_range("instant_send_latency", k, BUSY_WIN - 1, BUSY_WIN + 1);
        end else begin
            tx_ready = 1'b0;
            wait_outcome(TIMEOUT + 20, k);
            check_range("timeout_latency", k, TIMEOUT, TIMEOUT + 2);
            tx_ready = 1'b1;
        end
        if (done == '0 && err == '0) begin
            n_checks++; n_fail++;
            $display("FAIL outcome_timeout: no done/err after %0d cycles", k);
        end
        req = '0;
        @(negedge clk); #1;
        check("release_after_finish", {busy, grant, done, err}, '0);
        model_rr = (w + 1) % N_REQ;
    endtask

    task automatic reset_mid_op();
        int k;
        randomize_nums();
        exp_q.push_back({N_REQ'(1) << model_pick(N_REQ'(1), model_rr), 1'b0, pack_req(0)});
        @(negedge clk); #1;
        req = N_REQ'(1);
        req_new = '0;
        tx_ready = 1'b1;
        wait_send(k);
        check("mid_reset_send_seen", send_data, 1'b1);
        tx_ready = 1'b0;
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {grant, done, err, send_data, new_vector_incoming, busy, pack_tx()}, '0);
        req = '0;
        tx_ready = 1'b1;
        exp_q.delete();
        res_q.delete();
        model_rr = 0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("no_outcome_after_reset", {done, err, busy}, '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N_REQ-1:0] r;
        int mode;
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < N_NUMS; j++)
                req_nums[i][j] = '0;
        #100;
        check("power_on_reset", {grant, done, err, send_data, new_vector_incoming, busy, pack_tx()}, '0);
        @(negedge clk); #1 reset = 1'b0;

        // Single request with the reference vector.
        req_nums[0][0] = 16'hF6A5; req_nums[0][1] = 16'hFEDA; req_nums[0][2] = 16'hFD3C;
        req_nums[0][3] = 16'h00C1; req_nums[0][4] = 16'hDABE;
        run_round(2'b01, 2'b01, 0, 0, 20, 1'b0);

        // Contention from pointer 0: order 0,1,0,1.
        apply_reset();
        for (int n = 0; n < 4; n++) begin
            randomize_nums();
            req_nums[1][0] = 16'h5501;
            run_round(2'b11, 2'($urandom), 0, 0, $urandom_range(2, 10), 1'b0);
        end

        // Transmitter not ready for 50 cycles.
        randomize_nums();
        run_round(2'b01, 2'b00, 0, 50, 5, 1'b0);

        // Timeout, then instant-completing uart, then an early req drop.
        randomize_nums();
        run_round(2'b01, 2'b01, 2, 0, 0, 1'b0);
        randomize_nums();
        run_round(2'b10, 2'b10, 1, 0, 0, 1'b0);
        randomize_nums();
        run_round(2'b11, 2'b11, 0, 0, 4, 1'b1);

        // Reset while waiting for the uart to go idle; requester 0 first after.
        reset_mid_op();
        randomize_nums();
        run_round(2'b11, 2'b01, 0, 0, 3, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 24; n++) begin
            randomize_nums();
            r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            mode = ($urandom_range(0, 9) == 0) ? 2 : (($urandom_range(0, 4) == 0) ? 1 : 0);
            run_round(r, N_REQ'($urandom), mode, $urandom_range(0, 3),
                      $urandom_range(2, 15), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size() + res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
